// File: rtl/control_pipeline_if.sv
// rtl/control_pipeline_if.sv - control word bundle between decoder, hazard unit, datapath and control_pipeline
interface control_pipeline_if #(
  parameter int CNT_W = 32
);
  logic             InstrValidD;
  logic             RegWriteD;
  logic [1:0]       ResultSrcD;
  logic             MemWriteD;
  logic             JumpD;
  logic             BranchD;
  logic [1:0]       ALUSrcD;
  logic [2:0]       ALUControlD;
  logic             FlushE;
  logic             ZeroE;
  logic [1:0]       ALUSrcE;
  logic [2:0]       ALUControlE;
  logic             PCSrcE;
  logic             RegWriteM;
  logic             MemWriteM;
  logic [1:0]       ResultSrcM;
  logic             RegWriteW;
  logic [1:0]       ResultSrcW;
  logic [CNT_W-1:0] RetireCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output InstrValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
           ALUSrcD, ALUControlD, FlushE, ZeroE,
    input  ALUSrcE, ALUControlE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM,
           RegWriteW, ResultSrcW, RetireCnt, FlushCnt
  );

  modport slave (
    input  InstrValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
           ALUSrcD, ALUControlD, FlushE, ZeroE,
    output ALUSrcE, ALUControlE, PCSrcE, RegWriteM, MemWriteM, ResultSrcM,
           RegWriteW, ResultSrcW, RetireCnt, FlushCnt
  );
endinterface

// File: rtl/control_pipeline.sv
// rtl/control_pipeline.sv - ID/EX, EX/MEM, MEM/WB control-word registers and Execute PC select
// Optional retire/flush event counters are built when CTRL_PIPE_PERF_EN is defined.
module control_pipeline #(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  control_pipeline_if.slave bus
);

  logic       valid_e_q, valid_e_d;
  logic       reg_write_e_q, reg_write_e_d;
  logic [1:0] result_src_e_q, result_src_e_d;
  logic       mem_write_e_q, mem_write_e_d;
  logic       jump_e_q, jump_e_d;
  logic       branch_e_q, branch_e_d;
  logic [1:0] alu_src_e_q, alu_src_e_d;
  logic [2:0] alu_control_e_q, alu_control_e_d;

  logic       valid_m_q;
  logic       reg_write_m_q;
  logic [1:0] result_src_m_q;
  logic       mem_write_m_q;

  logic       valid_w_q;
  logic       reg_write_w_q;
  logic [1:0] result_src_w_q;

  // A flush overrides everything; a non-instruction keeps its mux selects but loses all side effects.
  always_comb begin
    valid_e_d       = 1'b0;
    reg_write_e_d   = 1'b0;
    result_src_e_d  = 2'b00;
    mem_write_e_d   = 1'b0;
    jump_e_d        = 1'b0;
    branch_e_d      = 1'b0;
    alu_src_e_d     = 2'b00;
    alu_control_e_d = 3'b000;
    if (!bus.FlushE) begin
      valid_e_d       = bus.InstrValidD;
      reg_write_e_d   = bus.RegWriteD & bus.InstrValidD;
      result_src_e_d  = bus.ResultSrcD;
      mem_write_e_d   = bus.MemWriteD & bus.InstrValidD;
      jump_e_d        = bus.JumpD & bus.InstrValidD;
      branch_e_d      = bus.BranchD & bus.InstrValidD;
      alu_src_e_d     = bus.ALUSrcD;
      alu_control_e_d = bus.ALUControlD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_e_q       <= 1'b0;
      reg_write_e_q   <= 1'b0;
      result_src_e_q  <= 2'b00;
      mem_write_e_q   <= 1'b0;
      jump_e_q        <= 1'b0;
      branch_e_q      <= 1'b0;
      alu_src_e_q     <= 2'b00;
      alu_control_e_q <= 3'b000;
      valid_m_q       <= 1'b0;
      reg_write_m_q   <= 1'b0;
      result_src_m_q  <= 2'b00;
      mem_write_m_q   <= 1'b0;
      valid_w_q       <= 1'b0;
      reg_write_w_q   <= 1'b0;
      result_src_w_q  <= 2'b00;
    end else begin
      valid_e_q       <= valid_e_d;
      reg_write_e_q   <= reg_write_e_d;
      result_src_e_q  <= result_src_e_d;
      mem_write_e_q   <= mem_write_e_d;
      jump_e_q        <= jump_e_d;
      branch_e_q      <= branch_e_d;
      alu_src_e_q     <= alu_src_e_d;
      alu_control_e_q <= alu_control_e_d;
      valid_m_q       <= valid_e_q;
      reg_write_m_q   <= reg_write_e_q;
      result_src_m_q  <= result_src_e_q;
      mem_write_m_q   <= mem_write_e_q;
      valid_w_q       <= valid_m_q;
      reg_write_w_q   <= reg_write_m_q;
      result_src_w_q  <= result_src_m_q;
    end
  end

  assign bus.ALUSrcE     = alu_src_e_q;
  assign bus.ALUControlE = alu_control_e_q;
  assign bus.PCSrcE      = valid_e_q & ((branch_e_q & bus.ZeroE) | jump_e_q);
  assign bus.RegWriteM   = reg_write_m_q;
  assign bus.MemWriteM   = mem_write_m_q;
  assign bus.ResultSrcM  = result_src_m_q;
  assign bus.RegWriteW   = reg_write_w_q;
  assign bus.ResultSrcW  = result_src_w_q;

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Both counters wrap naturally at 2^CNT_W.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (valid_w_q) begin
      retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    if (bus.FlushE && bus.InstrValidD) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      retire_cnt_q <= retire_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.RetireCnt = retire_cnt_q;
  assign bus.FlushCnt  = flush_cnt_q;
`else
  assign bus.RetireCnt = {CNT_W{1'b0}};
  assign bus.FlushCnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_control_pipeline.sv
// tb/tb_control_pipeline.sv - randomized and directed checks of control_pipeline against a stage-history model
module tb_control_pipeline;

  localparam int CW = 4;
`ifdef CTRL_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  control_pipeline_if #(.CNT_W(CW)) bus ();

  control_pipeline #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       j;
    logic       b;
    logic [1:0] as;
    logic [2:0] ac;
    logic       v;
  } ctrl_t;

  // hist[0] is the word now in E, hist[1] in M, hist[2] in W.
  ctrl_t       hist [3];
  ctrl_t       entering;
  int unsigned n_retire;
  int unsigned n_flush;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hist[i] = '0;
    n_retire = 0;
    n_flush  = 0;
  endtask

  always @(negedge rst) model_clear();

  always @(posedge clk) begin
    if (!rst) begin
      model_clear();
    end else begin
      if (hist[2].v) n_retire++;
      if (bus.FlushE && bus.InstrValidD) n_flush++;
      entering = '0;
      if (!bus.FlushE) begin
        entering.v  = bus.InstrValidD;
        entering.rw = bus.RegWriteD & bus.InstrValidD;
        entering.rs = bus.ResultSrcD;
        entering.mw = bus.MemWriteD & bus.InstrValidD;
        entering.j  = bus.JumpD & bus.InstrValidD;
        entering.b  = bus.BranchD & bus.InstrValidD;
        entering.as = bus.ALUSrcD;
        entering.ac = bus.ALUControlD;
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = entering;
    end
  end

  always @(negedge clk) begin
    check("ALUSrcE",     32'(bus.ALUSrcE),     32'(hist[0].as));
    check("ALUControlE", 32'(bus.ALUControlE), 32'(hist[0].ac));
    check("PCSrcE",      32'(bus.PCSrcE),
          32'(hist[0].v & ((hist[0].b & bus.ZeroE) | hist[0].j)));
    check("RegWriteM",   32'(bus.RegWriteM),   32'(hist[1].rw));
    check("MemWriteM",   32'(bus.MemWriteM),   32'(hist[1].mw));
    check("ResultSrcM",  32'(bus.ResultSrcM),  32'(hist[1].rs));
    check("RegWriteW",   32'(bus.RegWriteW),   32'(hist[2].rw));
    check("ResultSrcW",  32'(bus.ResultSrcW),  32'(hist[2].rs));
    check("RetireCnt",   32'(bus.RetireCnt),   PERF ? (n_retire % (1 << CW)) : 0);
    check("FlushCnt",    32'(bus.FlushCnt),    PERF ? (n_flush % (1 << CW)) : 0);
  end

  task automatic idle();
    bus.InstrValidD = 1'b0;
    bus.RegWriteD   = 1'b0;
    bus.ResultSrcD  = 2'b00;
    bus.MemWriteD   = 1'b0;
    bus.JumpD       = 1'b0;
    bus.BranchD     = 1'b0;
    bus.ALUSrcD     = 2'b00;
    bus.ALUControlD = 3'b000;
    bus.FlushE      = 1'b0;
    bus.ZeroE       = 1'b0;
  endtask

  task automatic rand_inputs(input bit allow_flush);
    bus.InstrValidD = ($urandom_range(3) != 0);
    bus.RegWriteD   = 1'($urandom);
    bus.ResultSrcD  = 2'($urandom_range(2));
    bus.MemWriteD   = 1'($urandom);
    bus.JumpD       = ($urandom_range(5) == 0);
    bus.BranchD     = ($urandom_range(3) == 0);
    bus.ALUSrcD     = 2'($urandom);
    bus.ALUControlD = 3'($urandom);
    bus.FlushE      = allow_flush && ($urandom_range(4) == 0);
    bus.ZeroE       = 1'($urandom);
  endtask

  // Inputs change 2 time units after the falling edge, clear of both the compare and the active edge.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    model_clear();
    idle();

    for (int i = 0; i < 5; i++) begin
      rand_inputs(1'b1);
      step();
    end
    bus.InstrValidD = 1'b1;
    bus.JumpD = 1'b1;
    bus.ZeroE = 1'b1;
    #1;
    check("rst_PCSrcE", 32'(bus.PCSrcE), 0);
    check("rst_RegWriteW", 32'(bus.RegWriteW), 0);
    check("rst_ALUSrcE", 32'(bus.ALUSrcE), 0);
    idle();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("idle_ALUControlE", 32'(bus.ALUControlE), 0);
    check("idle_RegWriteW", 32'(bus.RegWriteW), 0);
    check("idle_RetireCnt", 32'(bus.RetireCnt), 0);

    // LOAD
    bus.InstrValidD = 1'b1;
    bus.RegWriteD = 1'b1;
    bus.ResultSrcD = 2'b01;
    bus.ALUSrcD = 2'b01;
    step();
    idle();
    #1;
    check("load_ALUSrcE", 32'(bus.ALUSrcE), 1);
    step();
    check("load_RegWriteM", 32'(bus.RegWriteM), 1);
    check("load_ResultSrcM", 32'(bus.ResultSrcM), 1);
    step();
    check("load_RegWriteW", 32'(bus.RegWriteW), 1);
    check("load_ResultSrcW", 32'(bus.ResultSrcW), 1);
    check("load_RetireCnt0", 32'(bus.RetireCnt), 0);
    step();
    check("load_RetireCnt1", 32'(bus.RetireCnt), PERF ? 1 : 0);

    // BEQ taken, then not taken
    for (int z = 1; z >= 0; z--) begin
      bus.InstrValidD = 1'b1;
      bus.BranchD = 1'b1;
      step();
      idle();
      bus.ZeroE = 1'(z);
      #1;
      check("beq_PCSrcE", 32'(bus.PCSrcE), z);
      for (int k = 0; k < 3; k++) begin
        step();
        check("beq_RegWriteM", 32'(bus.RegWriteM), 0);
        check("beq_MemWriteM", 32'(bus.MemWriteM), 0);
        check("beq_RegWriteW", 32'(bus.RegWriteW), 0);
      end
    end
    step();
    check("beq_RetireCnt", 32'(bus.RetireCnt), PERF ? 3 : 0);

    // JAL flushed on entry
    bus.InstrValidD = 1'b1;
    bus.JumpD = 1'b1;
    bus.RegWriteD = 1'b1;
    bus.ResultSrcD = 2'b10;
    bus.FlushE = 1'b1;
    step();
    idle();
    bus.ZeroE = 1'b1;
    #1;
    check("flush_PCSrcE", 32'(bus.PCSrcE), 0);
    check("flush_FlushCnt", 32'(bus.FlushCnt), PERF ? 1 : 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("flush_RegWriteW", 32'(bus.RegWriteW), 0);
    end
    check("flush_RetireCnt", 32'(bus.RetireCnt), PERF ? 3 : 0);

    // JAL in E while the following instruction is flushed
    bus.InstrValidD = 1'b1;
    bus.JumpD = 1'b1;
    step();
    idle();
    bus.InstrValidD = 1'b1;
    bus.RegWriteD = 1'b1;
    bus.FlushE = 1'b1;
    #1;
    check("flushjal_PCSrcE", 32'(bus.PCSrcE), 1);
    step();
    idle();
    #1;
    check("flushjal_bubble", 32'(bus.PCSrcE), 0);
    check("flushjal_FlushCnt", 32'(bus.FlushCnt), PERF ? 2 : 0);
    for (int k = 0; k < 4; k++) step();
    check("flushjal_RetireCnt", 32'(bus.RetireCnt), PERF ? 4 : 0);

    // STORE then R-type, reset while STORE sits in M
    bus.InstrValidD = 1'b1;
    bus.MemWriteD = 1'b1;
    bus.ALUSrcD = 2'b01;
    step();
    idle();
    bus.InstrValidD = 1'b1;
    bus.RegWriteD = 1'b1;
    step();
    idle();
    check("mid_MemWriteM_before", 32'(bus.MemWriteM), 1);
    rst = 1'b0;
    #1;
    check("mid_MemWriteM_async", 32'(bus.MemWriteM), 0);
    check("mid_RetireCnt", 32'(bus.RetireCnt), 0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mid_MemWriteM", 32'(bus.MemWriteM), 0);
      check("mid_RegWriteW", 32'(bus.RegWriteW), 0);
    end

    for (int i = 0; i < 400; i++) begin
      rand_inputs(1'b1);
      step();
    end

    // Counter wrap with 17 back-to-back R-types
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.InstrValidD = 1'b1;
      bus.RegWriteD = 1'b1;
      bus.ALUControlD = 3'($urandom);
      step();
    end
    idle();
    for (int k = 0; k < 3; k++) step();
    check("wrap_RetireCnt", 32'(bus.RetireCnt), PERF ? 1 : 0);
    check("wrap_FlushCnt", 32'(bus.FlushCnt), 0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
# control_pipeline

Carries the control word produced by the main decoder in the Decode stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the five-stage RISC-V core. It resolves the Execute-stage PC select from Branch, Jump and the ALU Zero flag, and applies hazard-unit flushes as bubbles. It sits between the main/ALU decoders and the datapath stage muxes. Optionally, it keeps retire and flush event counters.

## Interface
Parameters:
- CNT_W, 32, width of the event counters (used only with CTRL_PIPE_PERF_EN)

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset
- InstrValidD  input  1  Decode stage holds a real instruction
- RegWriteD  input  1  register-file write enable from the decoder
- ResultSrcD  input  2  writeback mux select (00 ALU, 01 memory, 10 PC+4)
- MemWriteD  input  1  data-memory write enable
- JumpD  input  1  JAL
- BranchD  input  1  BEQ
- ALUSrcD  input  2  ALU B-operand select
- ALUControlD  input  3  ALU operation
- FlushE  input  1  hazard unit: insert a bubble into Execute
- ZeroE  input  1  ALU zero flag, Execute stage
- ALUSrcE  output  2  registered
- ALUControlE  output  3  registered
- PCSrcE  output  1  combinational: take branch/jump target
- RegWriteM  output  1  registered
- MemWriteM  output  1  registered
- ResultSrcM  output  2  registered; used by the hazard unit for load-use detection
- RegWriteW  output  1  registered
- ResultSrcW  output  2  registered
- RetireCnt  output  CNT_W  count of instructions reaching Writeback
- FlushCnt  output  CNT_W  count of valid instructions killed by FlushE

## Operation
- Per-stage control word: RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUSrc, ALUControl, plus a valid bit. Each later stage keeps only the fields it still needs.
  - E keeps all fields.
  - M keeps RegWrite, ResultSrc, MemWrite and valid.
  - W keeps RegWrite, ResultSrc and valid.
- ID/EX update, every cycle:
  - If FlushE=1, load a bubble: all fields 0 and validE=0.
  - Otherwise, load the D inputs and set validE=InstrValidD.
  - If InstrValidD=0, the captured RegWrite, MemWrite, Jump and Branch are forced to 0.
- EX/MEM and MEM/WB update unconditionally (no stall): M takes E, W takes M.
- PCSrcE = validE & ((BranchE & ZeroE) | JumpE).
- The block does not drive the Decode-side flush (FlushD); the hazard unit drives it from PCSrcE.

## Timing
- Reset (rst=0, asynchronous) clears every register and the validE/M/W bits, and clears both counters. All registered outputs read 0 and PCSrcE reads 0 while reset is held.
- Latency from a D input to its stage output:
  - E outputs: 1 cycle.
  - M outputs: 2 cycles.
  - W outputs: 3 cycles.
- PCSrcE is valid in the same cycle as ZeroE. It has no register.
- FlushE and a taken PCSrcE in the same cycle:
  - The instruction currently in E still drives PCSrcE.
  - The instruction entering E is bubbled at the next edge.
- Reset deasserted mid-stream: the pipeline restarts empty. No stale control word may reach W.
- Counters, updated on the rising edge:
  - RetireCnt increments when validW=1.
  - FlushCnt increments when FlushE=1 and InstrValidD=1.
  - Both wrap modulo 2^CNT_W with no saturation.
  - Both may increment in the same cycle.

## Configuration
- Macro: CTRL_PIPE_PERF_EN.
- Defined: RetireCnt and FlushCnt are implemented as described above.
- Undefined: no counter registers are built. RetireCnt and FlushCnt ports remain and are tied to 0. All other behaviour is identical.

## Test plan
- Reset: hold rst=0 with random inputs. Every output must be 0, including PCSrcE with JumpD=1 and ZeroE=1. Release rst; with no valid inputs, every output must still read 0.
- LOAD: drive RegWriteD=1, ResultSrcD=01, ALUSrcD=01, InstrValidD=1 for one cycle, then idle.
  - Next cycle: ALUSrcE=01.
  - Cycle 2: RegWriteM=1, ResultSrcM=01.
  - Cycle 3: RegWriteW=1, ResultSrcW=01.
  - RetireCnt goes 0 to 1.
- BEQ: issue BranchD=1.
  - In the E cycle with ZeroE=1, PCSrcE=1.
  - Repeated with ZeroE=0, PCSrcE=0.
  - RegWriteM, RegWriteW and MemWriteM stay 0 throughout.
- Flush: issue JAL (JumpD=1, RegWriteD=1, ResultSrcD=10) with FlushE=1 on that edge.
  - E holds a bubble: PCSrcE=0.
  - RegWriteW never asserts for this instruction.
  - FlushCnt=1 and RetireCnt is unchanged.
- Mid-stream reset: issue STORE then R-type, and pulse rst=0 while the STORE is in M.
  - MemWriteM drops to 0 immediately (asynchronous).
  - Neither instruction later asserts MemWriteM or RegWriteW.
- Wrap (CTRL_PIPE_PERF_EN, CNT_W=4): retire 17 back-to-back valid R-types. RetireCnt must read 1 after the 17th instruction retires. Without the macro, both counters read 0 throughout.
